// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM and alu_ctrl.
package mc_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEM_ADR  = 4'd2;
  localparam state_t S_MEM_RD   = 4'd3;
  localparam state_t S_MEM_WB   = 4'd4;
  localparam state_t S_MEM_WR   = 4'd5;
  localparam state_t S_EXEC     = 4'd6;
  localparam state_t S_R_WB     = 4'd7;
  localparam state_t S_BRANCH   = 4'd8;
  localparam state_t S_JUMP     = 4'd9;
  localparam state_t S_ORI_EXEC = 4'd10;
  localparam state_t S_ORI_WB   = 4'd11;
  localparam state_t S_HALT     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_OR   = 2'b11;

  localparam logic [1:0] ALUB_RT      = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multi-cycle MIPS core: sequences FETCH..WB and
// decodes every datapath mux/enable from the current state.
module mc_main_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_op,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic       o_i_or_d,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_mem_to_reg,
  output logic       o_reg_dst,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic       o_zero_ext,
  output logic [1:0] o_pc_source,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  // Memory handshake: a request (mem_read / mem_write) is held steady while
  // i_mem_ready is low and completes on the first edge where it is high.
  state_t state;
  state_t state_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:    state_nxt = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_op)
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_LW, OP_SW: state_nxt = S_MEM_ADR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ORI:       state_nxt = S_ORI_EXEC;
          default:      state_nxt = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      // IR is stable here, so the opcode is simply looked at again.
      S_MEM_ADR: begin
        if (i_op == OP_LW)      state_nxt = S_MEM_RD;
        else if (i_op == OP_SW) state_nxt = S_MEM_WR;
        else                    state_nxt = S_FETCH;
      end
      S_MEM_RD:   state_nxt = i_mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_nxt = S_FETCH;
      S_MEM_WR:   state_nxt = i_mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC:     state_nxt = S_R_WB;
      S_R_WB:     state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_JUMP:     state_nxt = S_FETCH;
      S_ORI_EXEC: state_nxt = S_ORI_WB;
      S_ORI_WB:   state_nxt = S_FETCH;
      S_HALT:     state_nxt = S_HALT;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_i_or_d        = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_ir_write      = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_reg_dst       = 1'b0;
    o_reg_write     = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = ALUB_RT;
    o_alu_op        = ALUOP_ADD;
    o_zero_ext      = 1'b0;
    o_pc_source     = PCSRC_ALU;
    o_illegal       = 1'b0;
    case (state)
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = ALUB_FOUR;
        // PC and IR only load on the cycle the instruction word arrives.
        o_pc_write  = i_mem_ready;
        o_ir_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_alu_src_b = ALUB_IMM_SH2;
        o_illegal   = !is_known_op(i_op);
      end
      S_MEM_ADR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = ALUB_IMM;
      end
      S_MEM_RD: begin
        o_mem_read = 1'b1;
        o_i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        o_mem_to_reg = 1'b1;
        o_reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        o_mem_write = 1'b1;
        o_i_or_d    = 1'b1;
      end
      S_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = ALUOP_FUNC;
      end
      S_R_WB: begin
        o_reg_dst   = 1'b1;
        o_reg_write = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a     = 1'b1;
        o_alu_op        = ALUOP_SUB;
        o_pc_write_cond = 1'b1;
        o_pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_pc_write  = 1'b1;
        o_pc_source = PCSRC_JUMP;
      end
      S_ORI_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = ALUB_IMM;
        o_alu_op    = ALUOP_OR;
        o_zero_ext  = 1'b1;
      end
      S_ORI_WB:   o_reg_write = 1'b1;
      S_HALT:     o_illegal   = 1'b1;
      default: ;
    endcase
  end

  assign o_state = state;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Bench for mc_main_ctrl: directed vector table, hand-written reset/trap
// sequences, then random instruction streams against a step-list model.
module tb_mc_main_ctrl;

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MW = 4'd4;
  localparam logic [3:0] MWR = 4'd5, EX = 4'd6, RW = 4'd7, BR = 4'd8, JP = 4'd9;
  localparam logic [3:0] OE = 4'd10, OW = 4'd11, HT = 4'd12;
  localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2b, BEQ = 6'h04;
  localparam logic [5:0] J = 6'h02, ORI = 6'h0d, BAD = 6'h3f;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       zero_ext;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
    logic [9:0] key;
  } vec_t;

  logic       i_clk, i_rst, i_mem_ready;
  logic [5:0] i_op;
  logic       a_pc_write, a_pc_write_cond, a_i_or_d, a_mem_read, a_mem_write, a_ir_write;
  logic       a_mem_to_reg, a_reg_dst, a_reg_write, a_alu_src_a, a_zero_ext, a_illegal;
  logic [1:0] a_alu_src_b, a_alu_op, a_pc_source;
  logic [3:0] a_state;
  logic       b_pc_write, b_pc_write_cond, b_i_or_d, b_mem_read, b_mem_write, b_ir_write;
  logic       b_mem_to_reg, b_reg_dst, b_reg_write, b_alu_src_a, b_zero_ext, b_illegal;
  logic [1:0] b_alu_src_b, b_alu_op, b_pc_source;
  logic [3:0] b_state;
  ctrl_t      act0, act1;

  int checks = 0;
  int passes = 0;

  ctrl_t      rows[16];
  vec_t       vec[$];
  logic [3:0] plan[$];
  logic [5:0] cur_op;
  logic       halted;

  mc_main_ctrl #(.TRAP_ON_ILLEGAL(1'b0)) dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_op(i_op), .i_mem_ready(i_mem_ready),
    .o_pc_write(a_pc_write), .o_pc_write_cond(a_pc_write_cond), .o_i_or_d(a_i_or_d),
    .o_mem_read(a_mem_read), .o_mem_write(a_mem_write), .o_ir_write(a_ir_write),
    .o_mem_to_reg(a_mem_to_reg), .o_reg_dst(a_reg_dst), .o_reg_write(a_reg_write),
    .o_alu_src_a(a_alu_src_a), .o_alu_src_b(a_alu_src_b), .o_alu_op(a_alu_op),
    .o_zero_ext(a_zero_ext), .o_pc_source(a_pc_source), .o_illegal(a_illegal),
    .o_state(a_state)
  );

  mc_main_ctrl #(.TRAP_ON_ILLEGAL(1'b1)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_op(i_op), .i_mem_ready(i_mem_ready),
    .o_pc_write(b_pc_write), .o_pc_write_cond(b_pc_write_cond), .o_i_or_d(b_i_or_d),
    .o_mem_read(b_mem_read), .o_mem_write(b_mem_write), .o_ir_write(b_ir_write),
    .o_mem_to_reg(b_mem_to_reg), .o_reg_dst(b_reg_dst), .o_reg_write(b_reg_write),
    .o_alu_src_a(b_alu_src_a), .o_alu_src_b(b_alu_src_b), .o_alu_op(b_alu_op),
    .o_zero_ext(b_zero_ext), .o_pc_source(b_pc_source), .o_illegal(b_illegal),
    .o_state(b_state)
  );

  assign act0 = {a_pc_write, a_pc_write_cond, a_i_or_d, a_mem_read, a_mem_write, a_ir_write,
                 a_mem_to_reg, a_reg_dst, a_reg_write, a_alu_src_a, a_alu_src_b, a_alu_op,
                 a_zero_ext, a_pc_source, a_illegal};
  assign act1 = {b_pc_write, b_pc_write_cond, b_i_or_d, b_mem_read, b_mem_write, b_ir_write,
                 b_mem_to_reg, b_reg_dst, b_reg_write, b_alu_src_a, b_alu_src_b, b_alu_op,
                 b_zero_ext, b_pc_source, b_illegal};

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic legal(input logic [5:0] op);
    return op == R || op == LW || op == SW || op == BEQ || op == J || op == ORI;
  endfunction

  function automatic logic [9:0] key_of(input ctrl_t c);
    return {c.pc_write, c.pc_write_cond, c.ir_write, c.reg_write, c.mem_read,
            c.mem_write, c.mem_to_reg, c.zero_ext, c.alu_op};
  endfunction

  // Control rows straight from the state table; FETCH loads and DECODE
  // illegal flag depend on inputs and are patched in exp_ctrl.
  task automatic init_rows();
    for (int i = 0; i < 16; i++) rows[i] = '0;
    rows[F].mem_read = 1; rows[F].alu_src_b = 2'b01; rows[F].pc_write = 1; rows[F].ir_write = 1;
    rows[D].alu_src_b = 2'b11;
    rows[MA].alu_src_a = 1; rows[MA].alu_src_b = 2'b10;
    rows[MR].mem_read = 1; rows[MR].i_or_d = 1;
    rows[MW].mem_to_reg = 1; rows[MW].reg_write = 1;
    rows[MWR].mem_write = 1; rows[MWR].i_or_d = 1;
    rows[EX].alu_src_a = 1; rows[EX].alu_op = 2'b10;
    rows[RW].reg_dst = 1; rows[RW].reg_write = 1;
    rows[BR].alu_src_a = 1; rows[BR].alu_op = 2'b01; rows[BR].pc_write_cond = 1;
    rows[BR].pc_source = 2'b01;
    rows[JP].pc_write = 1; rows[JP].pc_source = 2'b10;
    rows[OE].alu_src_a = 1; rows[OE].alu_src_b = 2'b10; rows[OE].alu_op = 2'b11;
    rows[OE].zero_ext = 1;
    rows[OW].reg_write = 1;
    rows[HT].illegal = 1;
  endtask

  function automatic ctrl_t exp_ctrl(input logic [3:0] s, input logic rdy, input logic [5:0] op);
    ctrl_t c;
    c = rows[s];
    if (s == F) begin
      c.pc_write = rdy;
      c.ir_write = rdy;
    end
    if (s == D) c.illegal = !legal(op);
    return c;
  endfunction

  // An instruction is the list of steps it walks through, from FETCH on.
  task automatic new_instr(input logic [5:0] op);
    cur_op = op;
    plan.delete();
    plan.push_back(F);
    plan.push_back(D);
    case (op)
      R:       begin plan.push_back(EX); plan.push_back(RW); end
      LW:      begin plan.push_back(MA); plan.push_back(MR); plan.push_back(MW); end
      SW:      begin plan.push_back(MA); plan.push_back(MWR); end
      BEQ:     plan.push_back(BR);
      J:       plan.push_back(JP);
      ORI:     begin plan.push_back(OE); plan.push_back(OW); end
      default: ;
    endcase
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops[7];
    ops = '{R, LW, SW, BEQ, J, ORI, 6'h00};
    ops[6] = 6'($urandom_range(0, 63));
    return ops[$urandom_range(0, 6)];
  endfunction

  task automatic model_advance(input logic rst, input logic rdy);
    logic [3:0] head;
    if (rst) begin
      halted = 1'b0;
      plan.delete();
    end else begin
      head = plan[0];
      if (!((head == F || head == MR || head == MWR) && !rdy)) begin
        if (head == D && !legal(cur_op)) halted = 1'b1;
        void'(plan.pop_front());
      end
    end
    if (plan.size() == 0) new_instr(pick_op());
  endtask

  // driver tasks: set inputs, settle to the falling edge for checks
  task automatic drive(input logic rst, input logic [5:0] op, input logic rdy);
    i_rst = rst;
    i_op = op;
    i_mem_ready = rdy;
    @(negedge i_clk);
  endtask

  task automatic next_edge();
    @(posedge i_clk);
    #1;
  endtask

  task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                     input logic pcw, input logic pcwc, input logic irw, input logic regw,
                     input logic mrd, input logic mwr, input logic m2r, input logic zext,
                     input logic [1:0] aluop);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st;
    v.key = {pcw, pcwc, irw, regw, mrd, mwr, m2r, zext, aluop};
    vec.push_back(v);
  endtask

  initial begin
    init_rows();
    i_rst = 1'b1; i_op = R; i_mem_ready = 1'b0;
    next_edge();
    next_edge();

    // reset state with memory not ready: FETCH row, no loads
    drive(1'b0, R, 1'b0);
    check("reset_state", 32'(a_state), 32'(F));
    check("reset_ctrl", 32'(act0), 32'(exp_ctrl(F, 1'b0, R)));
    next_edge();

    //   op   rdy st   pcw pcwc irw regw mrd mwr m2r zext aluop
    add(R,   1, F,   1, 0, 1, 0, 1, 0, 0, 0, 2'b00);
    add(R,   1, D,   0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    add(R,   1, EX,  0, 0, 0, 0, 0, 0, 0, 0, 2'b10);
    add(R,   1, RW,  0, 0, 0, 1, 0, 0, 0, 0, 2'b00);
    add(LW,  1, F,   1, 0, 1, 0, 1, 0, 0, 0, 2'b00);
    add(LW,  1, D,   0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    add(LW,  1, MA,  0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    add(LW,  0, MR,  0, 0, 0, 0, 1, 0, 0, 0, 2'b00);
    add(LW,  0, MR,  0, 0, 0, 0, 1, 0, 0, 0, 2'b00);
    add(LW,  1, MR,  0, 0, 0, 0, 1, 0, 0, 0, 2'b00);
    add(LW,  1, MW,  0, 0, 0, 1, 0, 0, 1, 0, 2'b00);
    add(ORI, 0, F,   0, 0, 0, 0, 1, 0, 0, 0, 2'b00);
    add(ORI, 0, F,   0, 0, 0, 0, 1, 0, 0, 0, 2'b00);
    add(ORI, 0, F,   0, 0, 0, 0, 1, 0, 0, 0, 2'b00);
    add(ORI, 1, F,   1, 0, 1, 0, 1, 0, 0, 0, 2'b00);
    add(ORI, 1, D,   0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    add(ORI, 1, OE,  0, 0, 0, 0, 0, 0, 0, 1, 2'b11);
    add(ORI, 1, OW,  0, 0, 0, 1, 0, 0, 0, 0, 2'b00);
    add(BEQ, 1, F,   1, 0, 1, 0, 1, 0, 0, 0, 2'b00);
    add(BEQ, 1, D,   0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    add(BEQ, 1, BR,  0, 1, 0, 0, 0, 0, 0, 0, 2'b01);
    add(J,   1, F,   1, 0, 1, 0, 1, 0, 0, 0, 2'b00);
    add(J,   1, D,   0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    add(J,   1, JP,  1, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    add(SW,  1, F,   1, 0, 1, 0, 1, 0, 0, 0, 2'b00);
    add(SW,  1, D,   0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    add(SW,  1, MA,  0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    add(SW,  0, MWR, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00);
    add(SW,  1, MWR, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00);
    add(R,   1, F,   1, 0, 1, 0, 1, 0, 0, 0, 2'b00);

    for (int i = 0; i < vec.size(); i++) begin
      drive(1'b0, vec[i].op, vec[i].rdy);
      check($sformatf("vec%0d_state", i), 32'(a_state), 32'(vec[i].st));
      check($sformatf("vec%0d_ctrl", i), 32'(key_of(act0)), 32'(vec[i].key));
      check($sformatf("vec%0d_trap_state", i), 32'(b_state), 32'(vec[i].st));
      next_edge();
    end

    // reset while MEM_RD is waiting on memory
    i_rst = 1'b1; next_edge(); i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, LW, 1'b1);
      next_edge();
    end
    drive(1'b1, LW, 1'b0);
    check("rst_mid_memrd_before", 32'(a_state), 32'(MR));
    next_edge();
    drive(1'b0, LW, 1'b0);
    check("rst_mid_memrd_state", 32'(a_state), 32'(F));
    check("rst_mid_memrd_ctrl", 32'(act0), 32'(exp_ctrl(F, 1'b0, LW)));
    check("rst_mid_memrd_trap", 32'(b_state), 32'(F));
    next_edge();

    // illegal opcode: skip vs trap
    drive(1'b0, BAD, 1'b1);
    next_edge();
    drive(1'b0, BAD, 1'b1);
    check("illegal_decode_state", 32'(a_state), 32'(D));
    check("illegal_decode_ctrl", 32'(act0), 32'(exp_ctrl(D, 1'b1, BAD)));
    check("illegal_decode_trap_ctrl", 32'(act1), 32'(exp_ctrl(D, 1'b1, BAD)));
    next_edge();
    drive(1'b0, BAD, 1'b0);
    check("illegal_skip_state", 32'(a_state), 32'(F));
    check("illegal_skip_flag", 32'(a_illegal), 32'(0));
    for (int i = 0; i < 12; i++) begin
      if (i != 0) drive(1'b0, BAD, 1'($urandom_range(0, 1)));
      check($sformatf("halt%0d_state", i), 32'(b_state), 32'(HT));
      check($sformatf("halt%0d_ctrl", i), 32'(act1), 32'(rows[HT]));
      next_edge();
    end
    drive(1'b1, R, 1'b0);
    next_edge();
    drive(1'b0, R, 1'b0);
    check("halt_reset_state", 32'(b_state), 32'(F));
    check("halt_reset_ctrl", 32'(act1), 32'(exp_ctrl(F, 1'b0, R)));
    next_edge();

    // random instruction stream against the step-list model
    i_rst = 1'b1; next_edge();
    halted = 1'b0;
    new_instr(pick_op());
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic rst, rdy;
      logic [3:0] exp_st;
      rst = ($urandom_range(0, 59) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      drive(rst, cur_op, rdy);
      exp_st = plan[0];
      check("rand_state", 32'(a_state), 32'(exp_st));
      check("rand_ctrl", 32'(act0), 32'(exp_ctrl(exp_st, rdy, cur_op)));
      check("rand_trap_state", 32'(b_state), 32'(halted ? HT : exp_st));
      check("rand_trap_ctrl", 32'(act1),
            32'(halted ? rows[HT] : exp_ctrl(exp_st, rdy, cur_op)));
      next_edge();
      model_advance(rst, rdy);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
Main control FSM of the multi-cycle MIPS core. It sits directly upstream of alu_ctrl: it decodes IR opcode, sequences FETCH/DECODE/EXEC/MEM/WB steps, and drives o_alu_op[1:0] into alu_ctrl's i_aluop along with every datapath mux/enable. Memory accesses stall on a ready handshake.

Parameters:
TRAP_ON_ILLEGAL, 0, 1 = an unknown opcode parks the FSM in HALT until reset; 0 = skip the instruction and return to FETCH.

Ports:
i_clk  in  1  clock; all state changes on the rising edge
i_rst  in  1  synchronous, active-high reset
i_op  in  6  IR[31:26]; valid from DECODE onward
i_mem_ready  in  1  memory completes the current read/write this cycle
o_pc_write  out  1  unconditional PC load
o_pc_write_cond  out  1  PC load if ALU zero (beq)
o_i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
o_mem_read  out  1  memory read request
o_mem_write  out  1  memory write request
o_ir_write  out  1  IR load
o_mem_to_reg  out  1  write-back data: 0 = ALUOut, 1 = MDR
o_reg_dst  out  1  destination register: 0 = rt, 1 = rd
o_reg_write  out  1  register file write enable
o_alu_src_a  out  1  ALU A: 0 = PC, 1 = rs
o_alu_src_b  out  2  ALU B: 00 = rt, 01 = 4, 10 = imm, 11 = imm<<2
o_alu_op  out  2  to alu_ctrl: 00 = add, 01 = sub, 10 = funct, 11 = or
o_zero_ext  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend
o_pc_source  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
o_illegal  out  1  unknown opcode seen in DECODE
o_state  out  4  current state, for debug

Behaviour:
- i_rst=1 at a clock edge puts state in FETCH, regardless of the current state, including mid-memory-wait and HALT.
- Outputs are decoded from state (Moore). Exception: o_pc_write and o_ir_write in FETCH are gated by i_mem_ready.
- After reset, outputs equal the FETCH row with i_mem_ready applied.
- Unlisted outputs are 0 in every state.
- State encoding: FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ORI_EXEC=10, ORI_WB=11, HALT=12. Codes 13-15 go to FETCH on the next edge.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, pc_write=ir_write=i_mem_ready. Holds until i_mem_ready=1, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by i_op:
  - 000000 -> EXEC
  - 100011 (lw) or 101011 (sw) -> MEM_ADR
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001101 (ori) -> ORI_EXEC
  - any other opcode: o_illegal=1 this cycle; next state is HALT if TRAP_ON_ILLEGAL, else FETCH.
- MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_RD for lw, MEM_WR for sw. i_op is re-sampled here; IR is stable.
- MEM_RD: mem_read=1, i_or_d=1. Holds until i_mem_ready, then MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1. Next is FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until i_mem_ready, then FETCH. mem_write stays high throughout the wait.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next is R_WB.
- R_WB: reg_dst=1, reg_write=1. Next is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next is FETCH.
- JUMP: pc_write=1, pc_source=10. Next is FETCH.
- ORI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11, zero_ext=1. Next is ORI_WB.
- ORI_WB: reg_dst=0, reg_write=1. Next is FETCH.
- HALT: all outputs 0, o_illegal=1. Held until reset.
- Latency in cycles with i_mem_ready tied high: lw 5, sw 4, R-type 4, ori 4, beq 3, j 3. Each stalled cycle adds exactly one cycle.
- Invariants: o_mem_read and o_mem_write are never both 1; o_reg_write never coincides with a memory request.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings (4-bit localparams)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ORI)
  - ALUOp constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNC=10, ALUOP_OR=11), shared with alu_ctrl
  - ALU B select constants
- No sub-module: one state register, one next-state block, one output decode block.

Test Plan:
- Reset mid-MEM_RD (i_mem_ready=0), i_rst=1 for one edge: next cycle o_state=0, o_mem_read=1, o_i_or_d=0.
- R-type add, i_op=000000, ready=1: states 0,1,6,7,0. In EXEC o_alu_op=10 and o_alu_src_b=00; in R_WB o_reg_dst=1 and o_reg_write=1.
- lw with i_mem_ready low for 2 cycles in MEM_RD: states 0,1,2,3,3,3,4,0; o_mem_to_reg=1 and o_reg_write=1 only in state 4.
- FETCH stall, ready=0 for 3 cycles: o_pc_write=o_ir_write=0 for those cycles, then 1 for exactly one cycle as the FSM moves to DECODE.
- ori then beq: in ORI_EXEC o_alu_op=11 and o_zero_ext=1. In BRANCH o_alu_op=01, o_pc_write_cond=1, o_pc_source=01, o_pc_write=0.
- i_op=111111:
  - TRAP_ON_ILLEGAL=0: o_illegal=1 in DECODE only, then FETCH.
  - TRAP_ON_ILLEGAL=1: FSM sits in HALT (o_state=12, all controls 0) for 10+ cycles until i_rst.
